// File: rtl/skintone_detector.sv
// Skin-tone pixel classifier: two-stage elastic pipeline that tags each YCrCb
// pixel with a skin mask byte and keeps saturating frame statistics.
module skintone_detector #(
   parameter int unsigned DATAIN_WIDTH  = 32,
   parameter int unsigned DATAOUT_WIDTH = 32,
   parameter int unsigned Y_MIN         = 40,
   parameter int unsigned CR_MIN        = 133,
   parameter int unsigned CR_MAX        = 173,
   parameter int unsigned CB_MIN        = 77,
   parameter int unsigned CB_MAX        = 127,
   parameter int unsigned COUNT_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATAIN_WIDTH-1:0]  datain,
   input  logic                     datain_valid,
   output logic                     datain_ready,
   output logic [DATAOUT_WIDTH-1:0] dataout,
   output logic                     dataout_valid,
   input  logic                     dataout_ready,
   input  logic                     count_clear,
   output logic [COUNT_WIDTH-1:0]   pixel_count,
   output logic [COUNT_WIDTH-1:0]   skin_count
);

   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] MASK_SKIN = 8'hFF;
   localparam logic [BYTE_W-1:0] MASK_NONE = 8'h00;

   logic [BYTE_W-1:0] in_y;
   logic [BYTE_W-1:0] in_cr;
   logic [BYTE_W-1:0] in_cb;
   logic              in_skin;
   logic              in_fire;
   logic              out_fire;
   logic              s1_adv;
   logic              s2_adv;

   logic              s1_valid;
   logic              s1_skin;
   logic [BYTE_W-1:0] s1_y;
   logic [BYTE_W-1:0] s1_cr;
   logic [BYTE_W-1:0] s1_cb;

   // The top input byte carries no pixel information and is dropped here.
   logic unused_top_byte;
   assign unused_top_byte = ^datain[31:24];

   assign in_y  = datain[23:16];
   assign in_cr = datain[15:8];
   assign in_cb = datain[7:0];

   // Inclusive window test; Y has no upper bound.
   assign in_skin = (in_y  >= BYTE_W'(Y_MIN))  &&
                    (in_cr >= BYTE_W'(CR_MIN)) && (in_cr <= BYTE_W'(CR_MAX)) &&
                    (in_cb >= BYTE_W'(CB_MIN)) && (in_cb <= BYTE_W'(CB_MAX));

   // Elastic handshake: a stage advances when it is empty or its consumer advances.
   assign s2_adv       = !dataout_valid || dataout_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign datain_ready = s1_adv && !rst;
   assign in_fire      = datain_valid && datain_ready;
   assign out_fire     = dataout_valid && dataout_ready;

   // Stage 1: capture pixel fields and classification result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_skin  <= 1'b0;
         s1_y     <= '0;
         s1_cr    <= '0;
         s1_cb    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1_skin <= in_skin;
            s1_y    <= in_y;
            s1_cr   <= in_cr;
            s1_cb   <= in_cb;
         end
      end
   end

   // Stage 2: assemble the output word with the mask byte on top.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataout_valid <= 1'b0;
         dataout       <= '0;
      end else if (s2_adv) begin
         dataout_valid <= s1_valid;
         if (s1_valid) begin
            dataout <= DATAOUT_WIDTH'({(s1_skin ? MASK_SKIN : MASK_NONE), s1_y, s1_cr, s1_cb});
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle transfer.
   always_ff @(posedge clk) begin
      if (rst || count_clear) begin
         pixel_count <= '0;
         skin_count  <= '0;
      end else if (out_fire) begin
         if (pixel_count != {COUNT_WIDTH{1'b1}}) begin
            pixel_count <= pixel_count + COUNT_WIDTH'(1);
         end
         if ((dataout[31:24] == MASK_SKIN) && (skin_count != {COUNT_WIDTH{1'b1}})) begin
            skin_count <= skin_count + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_skintone_detector.sv
// Bench for skintone_detector: queue-based reference model checked every cycle,
// plus directed literal checks (classification boundaries, backpressure, counter
// saturation/clear, reset mid-stream) and a randomized phase.
module tb_skintone_detector;

   logic        clk;
   logic        rst;
   logic [31:0] datain;
   logic        datain_valid;
   logic        dataout_ready;
   logic        count_clear;

   logic        datain_ready;
   logic [31:0] dataout;
   logic        dataout_valid;
   logic [31:0] pixel_count;
   logic [31:0] skin_count;

   logic        datain_ready4;
   logic [31:0] dataout4;
   logic        dataout_valid4;
   logic [3:0]  pixel_count4;
   logic [3:0]  skin_count4;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: pixels in flight with their age in cycles.
   logic [31:0] q_word[$];
   int          q_age[$];
   int unsigned m_pc32, m_sc32, m_pc4, m_sc4;
   bit          model_ok = 1'b0;
   int          out_seen = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   skintone_detector dut (
      .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid),
      .datain_ready(datain_ready), .dataout(dataout), .dataout_valid(dataout_valid),
      .dataout_ready(dataout_ready), .count_clear(count_clear),
      .pixel_count(pixel_count), .skin_count(skin_count)
   );

   skintone_detector #(.COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid),
      .datain_ready(datain_ready4), .dataout(dataout4), .dataout_valid(dataout_valid4),
      .dataout_ready(dataout_ready), .count_clear(count_clear),
      .pixel_count(pixel_count4), .skin_count(skin_count4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Classification straight from the threshold windows.
   function automatic logic [31:0] expect_word(input logic [31:0] w);
      int  y, cr, cb;
      bit  skin;
      y  = int'(w[23:16]);
      cr = int'(w[15:8]);
      cb = int'(w[7:0]);
      skin = (y >= 40) && (cr >= 133) && (cr <= 173) && (cb >= 77) && (cb <= 127);
      return {(skin ? 8'hFF : 8'h00), w[23:0]};
   endfunction

   // Per-cycle compare against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit          exp_v, exp_rdy, xo, acc, is_skin;
      logic [31:0] head;
      exp_v   = (q_word.size() > 0) && (q_age[0] >= 2);
      exp_rdy = !rst && ((q_word.size() < 2) || dataout_ready);
      head    = (q_word.size() > 0) ? q_word[0] : 32'h0;
      if (model_ok) begin
         check("datain_ready", 32'(datain_ready), 32'(exp_rdy));
         check("datain_ready_c4", 32'(datain_ready4), 32'(exp_rdy));
         check("dataout_valid", 32'(dataout_valid), 32'(exp_v));
         check("dataout_valid_c4", 32'(dataout_valid4), 32'(exp_v));
         if (exp_v) begin
            check("dataout", dataout, head);
            check("dataout_c4", dataout4, head);
         end
         check("pixel_count", pixel_count, m_pc32);
         check("skin_count", skin_count, m_sc32);
         check("pixel_count_c4", 32'(pixel_count4), m_pc4);
         check("skin_count_c4", 32'(skin_count4), m_sc4);
      end
      if (rst) begin
         q_word.delete();
         q_age.delete();
         m_pc32 = 0; m_sc32 = 0; m_pc4 = 0; m_sc4 = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         xo  = exp_v && dataout_ready;
         acc = datain_valid && exp_rdy;
         is_skin = (head[31:24] == 8'hFF);
         if (count_clear) begin
            m_pc32 = 0; m_sc32 = 0; m_pc4 = 0; m_sc4 = 0;
         end else if (xo) begin
            if (m_pc32 != 32'hFFFF_FFFF) m_pc32++;
            if (m_pc4 < 15) m_pc4++;
            if (is_skin) begin
               if (m_sc32 != 32'hFFFF_FFFF) m_sc32++;
               if (m_sc4 < 15) m_sc4++;
            end
         end
         if (xo) begin
            void'(q_word.pop_front());
            void'(q_age.pop_front());
            out_seen++;
         end
         foreach (q_age[i]) q_age[i]++;
         if (acc) begin
            q_word.push_back(expect_word(datain));
            q_age.push_back(1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send one pixel into an empty pipeline and pin the result with a literal.
   task automatic send_one(input string name, input logic [31:0] w, input logic [31:0] exp);
      datain = w;
      datain_valid = 1'b1;
      dataout_ready = 1'b1;
      step();
      datain_valid = 1'b0;
      step();
      check({name, "_out"}, dataout, exp);
      check({name, "_valid"}, 32'(dataout_valid), 32'd1);
      step();
      check({name, "_valid_after"}, 32'(dataout_valid), 32'd0);
   endtask

   logic [31:0] b_in  [10];
   logic [31:0] b_exp [10];

   initial begin
      int idx, cyc, start;
      bit fire;
      rst = 1'b1; datain = '0; datain_valid = 1'b0; dataout_ready = 1'b1; count_clear = 1'b0;
      repeat (3) step();
      check("rst_dataout", dataout, 32'h0);
      check("rst_valid", 32'(dataout_valid), 32'd0);
      check("rst_pixel_count", pixel_count, 32'd0);
      check("rst_skin_count", skin_count, 32'd0);
      check("rst_datain_ready", 32'(datain_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("release_datain_ready", 32'(datain_ready), 32'd1);

      send_one("skin", 32'hAB64_9664, 32'hFF64_9664);
      check("skin_pc", pixel_count, 32'd1);
      check("skin_sc", skin_count, 32'd1);
      send_one("nonskin", 32'h0064_7864, 32'h0064_7864);
      check("nonskin_pc", pixel_count, 32'd2);
      check("nonskin_sc", skin_count, 32'd1);

      b_in  = '{32'h0064_8564, 32'h0064_AD64, 32'h0064_AE64, 32'h0064_964D, 32'h0064_964C,
                32'h0028_9664, 32'h0027_9664, 32'h0064_8464, 32'h3364_967F, 32'h0064_9680};
      b_exp = '{32'hFF64_8564, 32'hFF64_AD64, 32'h0064_AE64, 32'hFF64_964D, 32'h0064_964C,
                32'hFF28_9664, 32'h0027_9664, 32'h0064_8464, 32'hFF64_967F, 32'h0064_9680};
      for (int i = 0; i < 10; i++) send_one($sformatf("bound%0d", i), b_in[i], b_exp[i]);

      // Backpressure: ready toggles 1,0,0,...
      idx = 0; cyc = 0; start = out_seen;
      while (idx < 10 && cyc < 200) begin
         datain = {8'h5A, 8'd100, ((idx % 2) != 0) ? 8'd120 : 8'd150, 8'(100 + idx)};
         datain_valid = 1'b1;
         dataout_ready = (cyc % 3) == 0;
         #1;
         fire = datain_ready;
         @(posedge clk); #1;
         if (fire) idx++;
         cyc++;
      end
      datain_valid = 1'b0;
      while ((out_seen - start) < 10 && cyc < 300) begin
         dataout_ready = (cyc % 3) == 0;
         step();
         cyc++;
      end
      check("bp_outputs", 32'(out_seen - start), 32'd10);
      dataout_ready = 1'b1;
      repeat (3) step();

      // Saturation with the 4-bit counters.
      count_clear = 1'b1; step(); count_clear = 1'b0;
      for (int i = 0; i < 20; i++) begin
         datain = {8'h00, 8'(60 + i), 8'd140, 8'd90};
         datain_valid = 1'b1;
         step();
      end
      datain_valid = 1'b0;
      repeat (3) step();
      check("sat_pc4", 32'(pixel_count4), 32'd15);
      check("sat_sc4", 32'(skin_count4), 32'd15);
      check("sat_pc32", pixel_count, 32'd20);

      // Clear coinciding with an output transfer.
      datain = 32'h0064_9664; datain_valid = 1'b1; step();
      datain_valid = 1'b0; step();
      check("clr_valid_before", 32'(dataout_valid), 32'd1);
      count_clear = 1'b1; step(); count_clear = 1'b0;
      check("clr_pc4", 32'(pixel_count4), 32'd0);
      check("clr_sc4", 32'(skin_count4), 32'd0);
      check("clr_pc32", pixel_count, 32'd0);
      check("clr_valid_after", 32'(dataout_valid), 32'd0);

      // Reset with two pixels in flight.
      send_one("pre_rst", 32'h0050_A070, 32'hFF50_A070);
      dataout_ready = 1'b0;
      datain = 32'h0064_9664; datain_valid = 1'b1; step();
      datain = 32'h0065_9665; step();
      datain_valid = 1'b0;
      rst = 1'b1; step();
      check("mid_rst_valid", 32'(dataout_valid), 32'd0);
      check("mid_rst_dataout", dataout, 32'h0);
      check("mid_rst_pc", pixel_count, 32'd0);
      rst = 1'b0; dataout_ready = 1'b1;
      #1;
      check("mid_rst_ready", 32'(datain_ready), 32'd1);
      repeat (2) begin
         step();
         check("mid_rst_no_stale", 32'(dataout_valid), 32'd0);
      end
      send_one("post_rst", 32'h0066_9966, 32'hFF66_9966);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         if (($urandom % 2) != 0)
            datain = {8'($urandom), 8'($urandom_range(30, 255)), 8'($urandom_range(125, 180)),
                      8'($urandom_range(70, 135))};
         else
            datain = $urandom;
         datain_valid  = ($urandom % 4) != 0;
         dataout_ready = ($urandom % 3) != 0;
         count_clear   = ($urandom % 60) == 0;
         rst           = ($urandom % 250) == 0;
         step();
      end
      rst = 1'b0; datain_valid = 1'b0; dataout_ready = 1'b1; count_clear = 1'b0;
      repeat (5) step();
      check("drain_empty", 32'(q_word.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/skintone_detector.md
Name: skintone_detector

Overview:
- Pixel-classification stage between rgb_to_ycrcb_converter and data_store, in the clk2 domain.
- Accepts one packed YCrCb pixel per cycle and classifies it as skin or non-skin using inclusive Y/Cr/Cb threshold windows.
- Emits the pixel with a mask byte in the top byte, ready for data_store's 32-bit datain.
- Keeps running total and skin pixel counters for frame statistics.

Parameters:
- DATAIN_WIDTH, 32, input word width; fixed layout, only 32 supported.
- DATAOUT_WIDTH, 32, output word width; only 32 supported.
- Y_MIN, 40, inclusive lower bound on Y.
- CR_MIN, 133, inclusive lower bound on Cr.
- CR_MAX, 173, inclusive upper bound on Cr.
- CB_MIN, 77, inclusive lower bound on Cb.
- CB_MAX, 127, inclusive upper bound on Cb.
- COUNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  pixel clock (clk2 at top level).
- rst  input  1  synchronous, active-high reset.
- datain  input  DATAIN_WIDTH  pixel: [31:24] ignored, [23:16] Y, [15:8] Cr, [7:0] Cb.
- datain_valid  input  1  upstream has a pixel.
- datain_ready  output  1  block can accept a pixel this cycle.
- dataout  output  DATAOUT_WIDTH  {mask[7:0], Y, Cr, Cb}; mask = 8'hFF for skin, 8'h00 otherwise.
- dataout_valid  output  1  dataout holds a pixel.
- dataout_ready  input  1  downstream accepts dataout.
- count_clear  input  1  synchronous clear of both counters.
- pixel_count  output  COUNT_WIDTH  pixels transferred out since reset/clear.
- skin_count  output  COUNT_WIDTH  skin pixels transferred out since reset/clear.

Behaviour:
- All logic on the rising edge of clk. Reset is synchronous and active-high. No other clock.
- Transfer rules:
  - Input transfer occurs on a cycle with datain_valid && datain_ready.
  - Output transfer occurs on a cycle with dataout_valid && dataout_ready.
- Two-stage elastic pipeline.
  - S1 registers Y/Cr/Cb and the compare result.
  - S2 registers the output word.
  - Each stage has its own valid flag.
- Skin test, inclusive on all bounds, unsigned 8-bit compares: Y >= Y_MIN && CR_MIN <= Cr <= CR_MAX && CB_MIN <= Cb <= CB_MAX. No upper bound on Y.
- Advance and ready logic:
  - s2_adv = !s2_valid || dataout_ready.
  - s1_adv = !s1_valid || s2_adv.
  - datain_ready = s1_adv && !rst (combinational).
- Timing:
  - Latency: a pixel accepted in cycle N is presented with dataout_valid=1 in cycle N+2 when there is no backpressure.
  - Throughput is 1 pixel/cycle when dataout_ready is held high.
- Backpressure:
  - While dataout_valid=1 and dataout_ready=0, dataout is held stable and the pipeline holds.
  - After one further accepted pixel fills S1, datain_ready=0.
  - No pixel is dropped or duplicated.
- Input byte [31:24] is discarded; it never reaches dataout.
- Counters:
  - On each output transfer, pixel_count increments by 1, and skin_count increments by 1 if mask=8'hFF.
  - Both counters saturate at 2^COUNT_WIDTH-1; no wrap.
  - count_clear=1 zeroes both counters. Clear has priority over a same-cycle increment; that transfer is not counted.
  - count_clear does not affect the data pipeline.
- Reset values: dataout=0, dataout_valid=0, S1/S2 valid=0, pixel_count=0, skin_count=0.
  - datain_ready=0 while rst=1 and 1 in the first cycle after release.
- Reset mid-operation discards all in-flight pixels. No partial output follows reset.

Test Plan:
- Single skin pixel datain=32'hAB64_9664 (Y=100, Cr=150, Cb=100), dataout_ready=1 -> after 2 cycles dataout=32'hFF64_9664, dataout_valid for 1 cycle; pixel_count=1, skin_count=1.
- Non-skin pixel datain=32'h0064_7864 (Cr=120) -> dataout=32'h0064_7864; pixel_count increments, skin_count unchanged.
- Boundaries, each giving the listed mask:
  - Cr=133 -> FF; Cr=173 -> FF; Cr=174 -> 00.
  - Cb=77 -> FF; Cb=76 -> 00.
  - Y=40 -> FF; Y=39 -> 00.
  - All other fields held inside their windows.
- Backpressure: stream 10 pixels with dataout_ready toggling 1,0,0,1,... -> 10 outputs, in order, values intact, dataout stable while stalled; datain_ready=0 whenever both stages are full and the output stalls.
- Counters with COUNT_WIDTH=4: 20 skin pixels -> both counters saturate at 15. Then assert count_clear in the same cycle as an output transfer -> both read 0 next cycle.
- Reset mid-stream, with 2 pixels in flight -> dataout_valid=0 next cycle, counters 0, no stale pixel emitted after release; next accepted pixel appears 2 cycles later.
